// File: rtl/systolic_ctrl.sv
// Sequencer for one NxN systolic matmul tile: clear, feed K operand
// vectors, drain the skew/PE pipeline, then write back N result rows.
module systolic_ctrl #(
  parameter int ARRAY_SIZE = 4,
  parameter int K_WIDTH    = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int ROW_WIDTH  = $clog2(ARRAY_SIZE)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [K_WIDTH-1:0]    k_len_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic                  abort_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  clear_o,
  output logic                  rd_en_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  output logic                  feed_valid_o,
  output logic                  wr_en_o,
  output logic [ROW_WIDTH-1:0]  wr_row_o
);

  localparam int DRAIN_LEN = 2 * ARRAY_SIZE + 1;
  localparam int DW = $clog2(DRAIN_LEN);
  localparam int CW = (K_WIDTH > DW) ? K_WIDTH : DW;

  typedef enum logic [2:0] {
    IDLE, CLEAR, FEED, DRAIN, WB, DONE
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0]         cnt;
  logic [K_WIDTH-1:0]    k_len;
  logic [K_WIDTH-1:0]    k_last;
  logic [ADDR_WIDTH-1:0] base;
  logic                  accept;
  logic                  feed_last;
  logic                  drain_last;
  logic                  wb_last;

  // abort in IDLE swallows a simultaneous start
  assign accept     = (state == IDLE) && start_i && !abort_i;
  assign k_last     = k_len - K_WIDTH'(1);
  assign feed_last  = (cnt == CW'(k_last));
  assign drain_last = (cnt == CW'(DRAIN_LEN - 1));
  assign wb_last    = (cnt == CW'(ARRAY_SIZE - 1));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nx = (k_len_i == '0) ? DONE : CLEAR;
        end
      end
      CLEAR: state_nx = FEED;
      FEED:  if (feed_last)  state_nx = DRAIN;
      DRAIN: if (drain_last) state_nx = WB;
      WB:    if (wb_last)    state_nx = DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (abort_i) begin
      state_nx = IDLE;
    end
  end

  // shared phase counter restarts at 0 on every state change
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt          <= '0;
      k_len        <= '0;
      base         <= '0;
      feed_valid_o <= 1'b0;
    end else begin
      if (state_nx != state) begin
        cnt <= '0;
      end else if (state != IDLE) begin
        cnt <= cnt + CW'(1);
      end
      if (accept) begin
        k_len <= k_len_i;
        base  <= base_addr_i;
      end
      feed_valid_o <= rd_en_o && !abort_i;
    end
  end

  always_comb begin
    busy_o    = 1'b0;
    done_o    = 1'b0;
    clear_o   = 1'b0;
    rd_en_o   = 1'b0;
    rd_addr_o = '0;
    wr_en_o   = 1'b0;
    wr_row_o  = '0;
    unique case (state)
      IDLE: ;
      CLEAR: begin
        busy_o  = 1'b1;
        clear_o = 1'b1;
      end
      FEED: begin
        busy_o    = 1'b1;
        rd_en_o   = 1'b1;
        rd_addr_o = base + ADDR_WIDTH'(cnt);
      end
      DRAIN: busy_o = 1'b1;
      WB: begin
        busy_o   = 1'b1;
        wr_en_o  = 1'b1;
        wr_row_o = ROW_WIDTH'(cnt);
      end
      DONE: begin
        busy_o = 1'b1;
        done_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_systolic_ctrl.sv
// Bench for systolic_ctrl: fixed table for the K=3 run, hand sequences
// for K=0, wrap, abort and reset, and random commands vs a timeline model.
module tb_systolic_ctrl;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] k_len;
  logic [7:0] base_addr;
  logic       abort;
  logic       busy, done, clear, rd_en, feed_valid, wr_en;
  logic [7:0] rd_addr;
  logic [1:0] wr_row;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       clear;
    logic       rd_en;
    logic [7:0] addr;
    logic       fv;
    logic       wr_en;
    logic [1:0] row;
  } out_t;

  typedef struct {
    int   cyc;
    out_t exp;
  } vec_t;

  systolic_ctrl #(
    .ARRAY_SIZE(N), .K_WIDTH(8), .ADDR_WIDTH(8)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start),
    .k_len_i(k_len), .base_addr_i(base_addr), .abort_i(abort),
    .busy_o(busy), .done_o(done), .clear_o(clear),
    .rd_en_o(rd_en), .rd_addr_o(rd_addr),
    .feed_valid_o(feed_valid), .wr_en_o(wr_en), .wr_row_o(wr_row)
  );

  always #5 clk = ~clk;

  function automatic out_t act();
    out_t o;
    o.busy = busy; o.done = done; o.clear = clear;
    o.rd_en = rd_en; o.addr = rd_addr; o.fv = feed_valid;
    o.wr_en = wr_en; o.row = wr_row;
    return o;
  endfunction

  task automatic check(input string name, input int t, input out_t exp);
    out_t a = act();
    n_checks++;
    if (a !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0d got busy%b done%b clr%b rd%b a%h fv%b wr%b r%0d exp busy%b done%b clr%b rd%b a%h fv%b wr%b r%0d",
        name, t, a.busy, a.done, a.clear, a.rd_en, a.addr, a.fv,
        a.wr_en, a.row, exp.busy, exp.done, exp.clear, exp.rd_en,
        exp.addr, exp.fv, exp.wr_en, exp.row);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected outputs t cycles after the start cycle (t=0), from the
  // phase lengths: clear 1, feed K, drain 2N+1, write-back N, done 1.
  function automatic int done_cyc(input int k);
    return (k == 0) ? 1 : 1 + k + (2 * N + 1) + N + 1;
  endfunction

  function automatic out_t model(input int t, input int k,
                                 input int b, input int ab);
    out_t o = '0;
    int wb0, dn;
    if (t <= 0) return o;
    if (ab >= 0 && t > ab) return o;
    if (k == 0) begin
      if (t == 1) begin o.busy = 1; o.done = 1; end
      return o;
    end
    dn  = done_cyc(k);
    wb0 = dn - N;
    o.busy  = (t <= dn);
    o.clear = (t == 1);
    o.rd_en = (t >= 2 && t <= k + 1);
    if (o.rd_en) o.addr = 8'((b + t - 2) % 256);
    o.fv    = (t >= 3 && t <= k + 2);
    o.wr_en = (t >= wb0 && t < dn);
    if (o.wr_en) o.row = 2'(t - wb0);
    o.done  = (t == dn);
    return o;
  endfunction

  task automatic run_cmd(input string name, input int k, input int b,
                         input int ab, input bit hold);
    int dn   = done_cyc(k);
    int last = (ab >= 0) ? ab : dn;
    start     = 1'b1;
    k_len     = 8'(k);
    base_addr = 8'(b);
    abort     = (ab == 0);
    check(name, 0, model(0, k, b, ab));
    for (int t = 1; t <= dn + 2; t++) begin
      step();
      start = hold && (t < last);
      abort = (t == ab);
      check(name, t, model(t, k, b, ab));
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  vec_t tbl[$];

  function automatic out_t mk(input bit bsy, input bit dn, input bit cl,
                              input bit rd, input int ad, input bit fv,
                              input bit wr, input int rw);
    out_t o;
    o.busy = bsy; o.done = dn; o.clear = cl; o.rd_en = rd;
    o.addr = 8'(ad); o.fv = fv; o.wr_en = wr; o.row = 2'(rw);
    return o;
  endfunction

  initial begin
    int t;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    k_len = '0; base_addr = '0;

    tbl.push_back('{0,  mk(0,0,0,0,'h00,0,0,0)});
    tbl.push_back('{1,  mk(1,0,1,0,'h00,0,0,0)});
    tbl.push_back('{2,  mk(1,0,0,1,'h10,0,0,0)});
    tbl.push_back('{3,  mk(1,0,0,1,'h11,1,0,0)});
    tbl.push_back('{4,  mk(1,0,0,1,'h12,1,0,0)});
    tbl.push_back('{5,  mk(1,0,0,0,'h00,1,0,0)});
    tbl.push_back('{6,  mk(1,0,0,0,'h00,0,0,0)});
    tbl.push_back('{13, mk(1,0,0,0,'h00,0,0,0)});
    tbl.push_back('{14, mk(1,0,0,0,'h00,0,1,0)});
    tbl.push_back('{15, mk(1,0,0,0,'h00,0,1,1)});
    tbl.push_back('{16, mk(1,0,0,0,'h00,0,1,2)});
    tbl.push_back('{17, mk(1,0,0,0,'h00,0,1,3)});
    tbl.push_back('{18, mk(1,1,0,0,'h00,0,0,0)});
    tbl.push_back('{19, mk(0,0,0,0,'h00,0,0,0)});

    step(); step();
    check("reset", 0, '0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("idle", i, '0);
    end

    // K=3, base 0x10 against the literal timeline table
    start = 1'b1; k_len = 8'd3; base_addr = 8'h10;
    t = 0;
    foreach (tbl[i]) begin
      while (t < tbl[i].cyc) begin
        step();
        start = 1'b0;
        t++;
      end
      check("table_k3", t, tbl[i].exp);
    end
    step();

    run_cmd("k0", 0, 'h33, -1, 1'b0);
    run_cmd("wrap", 4, 'hFE, -1, 1'b0);
    run_cmd("abort_feed", 5, 'h20, 4, 1'b1);
    run_cmd("after_abort", 3, 'h10, -1, 1'b0);
    run_cmd("abort_idle", 3, 'h10, 0, 1'b0);
    run_cmd("kmax", 255, 'h80, -1, 1'b0);

    // reset asserted during write-back row 2, with start alongside
    start = 1'b1; k_len = 8'd3; base_addr = 8'h10;
    for (t = 1; t <= 16; t++) begin
      step();
      start = 1'b0;
    end
    check("wb_row2", 16, mk(1,0,0,0,0,0,1,2));
    rst_n = 1'b0; start = 1'b1;
    step();
    rst_n = 1'b1; start = 1'b0;
    check("rst_wb", 17, '0);
    step();
    check("rst_no_start", 18, '0);
    step();

    for (int r = 0; r < 25; r++) begin
      int k  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 12);
      int b  = $urandom_range(0, 255);
      int ab = -1;
      if ($urandom_range(0, 1) == 1) ab = $urandom_range(0, done_cyc(k));
      run_cmd("random", k, b, ab, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
